if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Parametrised fetch front end: generates the PC, reads the instruction ROM and buffers
//  {pc, instr, pred_taken} in a DEPTH-entry FIFO that decouples fetch from the ID stage.
//  Sits between the instruction ROM / branch predictor and the IF/ID register.
//  Accepts a same-cycle predicted redirect from the IF predictor and a flush redirect
//  (branch-failed rollback) from later stages.
// PARAMETERS
//  XLEN      32            address/instruction width
//  DEPTH     4             FIFO entries; power of 2, >= 2
//  RESET_PC  32'h00000000  PC loaded on reset
//  NOP       32'h00000013  instruction presented on deq_instr when the FIFO is empty
// PORTS
//  clk             in   1             clock, all state on rising edge
//  rst             in   1             synchronous reset, active-high
//  rom_addr        out  XLEN          current fetch PC; ROM returns rom_instr in the same cycle
//  rom_instr       in   XLEN          instruction at rom_addr
//  pred_taken      in   1             IF predictor: instruction at rom_addr redirects fetch
//  pred_pc         in   XLEN          predicted target, valid when pred_taken=1
//  redirect_valid  in   1             flush/rollback from a later stage
//  redirect_pc     in   XLEN          rollback PC
//  deq_ready       in   1             ID stage accepts the head entry this cycle
//  deq_valid       out  1             head entry valid
//  deq_instr       out  XLEN          head instruction (NOP when empty)
//  deq_pc          out  XLEN          head PC (0 when empty)
//  deq_pred_taken  out  1             head prediction bit (0 when empty)
//  count           out  $clog2(DEPTH)+1  occupied entries
//  full            out  1             count == DEPTH
//  empty           out  1             count == 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc=RESET_PC, wr_ptr=rd_ptr=0, count=0. Outputs after reset:
//    rom_addr=RESET_PC, deq_valid=0, deq_instr=NOP, deq_pc=0, deq_pred_taken=0,
//    empty=1, full=0. Reset mid-operation discards all entries; it overrides every other input.
//  - deq_fire = deq_valid & deq_ready.
//  - enq_ok = ~full | deq_fire. Space freed by a same-cycle dequeue is reusable.
//  - Priority each cycle: rst > redirect_valid > normal fetch.
//  - Redirect: next pc = {redirect_pc[XLEN-1:2],2'b00}. Pointers and count are cleared.
//    No enqueue occurs, and any deq_fire in that cycle is discarded (ID is flushed too).
//    pred_taken is ignored.
//  - Normal fetch, enq_ok=1: write {rom_addr, rom_instr, pred_taken} at wr_ptr.
//    Next pc = pred_taken ? {pred_pc[XLEN-1:2],2'b00} : pc+4 (mod 2^XLEN, wraps silently).
//  - Normal fetch, enq_ok=0: pc holds and nothing is written; the ROM is re-read next cycle.
//  - count' = count + enq - deq, so a simultaneous enq and deq leaves count unchanged.
//    Pointers increment mod DEPTH (DEPTH-1 -> 0).
//  - deq_* are a combinational read of the entry at rd_ptr, gated to reset values when empty.
//  - Latency: an instruction fetched in cycle t is visible on deq_* in cycle t+1 at the earliest.
//  - count never exceeds DEPTH. deq_ready with empty=1 has no effect.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> rom_addr=0x0, deq_valid=0, deq_instr=0x13, count=0, empty=1.
//  2 Fill, DEPTH=4, deq_ready=0, pred_taken=0 -> after 4 cycles count=4, full=1,
//    rom_addr holds 0x10. One deq_ready pulse -> deq_pc=0x0 consumed, 0x10 enqueued same
//    cycle, count stays 4.
//  3 Prediction: pred_taken=1 at rom_addr=0x8, pred_pc=0x42 -> next rom_addr=0x40; the
//    entry for 0x8 dequeues with deq_pred_taken=1, and the following entry has deq_pc=0x40.
//  4 Redirect while full, redirect_pc=0x100 with deq_ready=1 -> next cycle count=0, empty=1,
//    rom_addr=0x100; one cycle later deq_pc=0x100, deq_valid=1.
//  5 Streaming, deq_ready=1 for 12 cycles from 0x0 -> deq_pc sequence 0x0,0x4,... in order
//    across pointer wrap, count stays 1. Start at pc=0xFFFFFFFC -> next pc=0x0.
//  6 Simultaneous redirect_valid=1 and pred_taken=1 -> redirect_pc wins. rst=1 during
//    streaming -> next cycle rom_addr=RESET_PC, count=0.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Dequeue handshake between the fetch queue and the ID stage.
// The queue presents the head entry and the consumer returns ready.
interface if_fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic            pred_taken;

  modport master (
    output valid,
    output instr,
    output pc,
    output pred_taken,
    input  ready
  );

  modport slave (
    input  valid,
    input  instr,
    input  pc,
    input  pred_taken,
    output ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch front end: PC generation, ROM read and a DEPTH-entry
// {pc, instr, pred_taken} FIFO feeding the ID stage.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        rom_addr,
  input  logic [XLEN-1:0]        rom_instr,
  input  logic                   pred_taken,
  input  logic [XLEN-1:0]        pred_pc,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  if_fetch_queue_if.master       deq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_next;
  logic [XLEN-1:0]  mem_pc    [DEPTH];
  logic [XLEN-1:0]  mem_instr [DEPTH];
  logic [DEPTH-1:0] mem_pt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             deq_fire;
  logic             enq_ok;
  logic             enq;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign deq_fire = ~empty & deq.ready;
  assign enq_ok   = ~full | deq_fire;
  assign enq      = ~rst & ~redirect_valid & enq_ok;
  assign rom_addr = pc;

  assign pc_next = pred_taken ? {pred_pc[XLEN-1:2], 2'b00}
                              : pc + XLEN'(4);

  assign deq.valid      = ~empty;
  assign deq.instr      = empty ? NOP  : mem_instr[rd_ptr];
  assign deq.pc         = empty ? '0   : mem_pc[rd_ptr];
  assign deq.pred_taken = empty ? 1'b0 : mem_pt[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= rom_instr;
      mem_pt[wr_ptr]    <= pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // ID is flushed as well, so a same-cycle dequeue is dropped.
      pc     <= {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
        pc     <= pc_next;
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(enq_ok) - CW'(deq_fire);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a queue model predicts every
// enqueue and the head entry is compared whenever ID could consume it.
module tb_if_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  if_fetch_queue_if #(.XLEN(XLEN)) dq ();

  if_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .NOP      (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .pred_taken     (pred_taken),
    .pred_pc        (pred_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq            (dq),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  always_comb rom_instr = rom_fn(rom_addr);

  int          vecs = 0;
  int          errs = 0;
  ent_t        sb[$];
  logic [31:0] m_pc;

  // Drive one cycle of inputs, advance the model, return 1ns past the edge.
  task automatic tick(input logic r, input logic rv,
                      input logic [31:0] rpc, input logic pt,
                      input logic [31:0] ppc, input logic rdy);
    logic fire;
    logic ok;
    ent_t e;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    pred_taken     = pt;
    pred_pc        = ppc;
    dq.ready       = rdy;
    fire = rdy && (sb.size() != 0);
    ok   = (sb.size() != DEPTH) || fire;
    if (r) begin
      m_pc = 32'h0;
      sb.delete();
    end else if (rv) begin
      m_pc = {rpc[31:2], 2'b00};
      sb.delete();
    end else begin
      if (fire) void'(sb.pop_front());
      if (ok) begin
        e.pc    = m_pc;
        e.instr = rom_fn(m_pc);
        e.pt    = pt;
        sb.push_back(e);
        m_pc = pt ? {ppc[31:2], 2'b00} : m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0);
    vecs++; if (rom_addr !== 32'h0) begin errs++; $display("FAIL reset_rom_addr got %h want 00000000", rom_addr); end
    vecs++; if (dq.valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", dq.valid); end
    vecs++; if (dq.instr !== 32'h13) begin errs++; $display("FAIL reset_instr got %h want 00000013", dq.instr); end
    vecs++; if (dq.pc !== 32'h0) begin errs++; $display("FAIL reset_pc got %h want 00000000", dq.pc); end
    vecs++; if (dq.pred_taken !== 1'b0) begin errs++; $display("FAIL reset_pt got %b want 0", dq.pred_taken); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", empty); end
    vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", full); end
  endtask

  task automatic test_fill;
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_count got %0d want 4", count); end
    vecs++; if (full !== 1'b1) begin errs++; $display("FAIL fill_full got %b want 1", full); end
    vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL fill_empty got %b want 0", empty); end
    vecs++; if (rom_addr !== 32'h10) begin errs++; $display("FAIL fill_rom_addr got %h want 00000010", rom_addr); end
    tick(0, 0, 0, 0, 0, 0);
    vecs++; if (rom_addr !== 32'h10) begin errs++; $display("FAIL fill_hold got %h want 00000010", rom_addr); end
    vecs++; if (dq.pc !== 32'h0) begin errs++; $display("FAIL fill_head got %h want 00000000", dq.pc); end
    vecs++; if (dq.instr !== sb[0].instr) begin errs++; $display("FAIL fill_head_instr got %h want %h", dq.instr, sb[0].instr); end
    tick(0, 0, 0, 0, 0, 1);
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_pulse_count got %0d want 4", count); end
    vecs++; if (dq.pc !== 32'h4) begin errs++; $display("FAIL fill_pulse_head got %h want 00000004", dq.pc); end
    vecs++; if (rom_addr !== 32'h14) begin errs++; $display("FAIL fill_pulse_rom got %h want 00000014", rom_addr); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (dq.pc !== sb[0].pc || dq.instr !== sb[0].instr) begin errs++; $display("FAIL fill_drain pc %h instr %h want pc %h instr %h", dq.pc, dq.instr, sb[0].pc, sb[0].instr); end
      tick(0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_predict;
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    vecs++; if (rom_addr !== 32'h8) begin errs++; $display("FAIL pred_pre_addr got %h want 00000008", rom_addr); end
    tick(0, 0, 0, 1, 32'h42, 1);
    vecs++; if (rom_addr !== 32'h40) begin errs++; $display("FAIL pred_target got %h want 00000040", rom_addr); end
    vecs++; if (dq.pc !== 32'h8) begin errs++; $display("FAIL pred_head_pc got %h want 00000008", dq.pc); end
    vecs++; if (dq.pred_taken !== 1'b1) begin errs++; $display("FAIL pred_head_bit got %b want 1", dq.pred_taken); end
    tick(0, 0, 0, 0, 0, 1);
    vecs++; if (dq.pc !== 32'h40) begin errs++; $display("FAIL pred_next_pc got %h want 00000040", dq.pc); end
    vecs++; if (dq.pred_taken !== 1'b0) begin errs++; $display("FAIL pred_next_bit got %b want 0", dq.pred_taken); end
    vecs++; if (dq.instr !== rom_fn(32'h40)) begin errs++; $display("FAIL pred_next_instr got %h want %h", dq.instr, rom_fn(32'h40)); end
  endtask

  task automatic test_redirect;
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);
    vecs++; if (full !== 1'b1) begin errs++; $display("FAIL redir_prefull got %b want 1", full); end
    tick(0, 1, 32'h100, 0, 0, 1);
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL redir_count got %0d want 0", count); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL redir_empty got %b want 1", empty); end
    vecs++; if (rom_addr !== 32'h100) begin errs++; $display("FAIL redir_addr got %h want 00000100", rom_addr); end
    vecs++; if (dq.valid !== 1'b0) begin errs++; $display("FAIL redir_valid got %b want 0", dq.valid); end
    tick(0, 0, 0, 0, 0, 0);
    vecs++; if (dq.valid !== 1'b1) begin errs++; $display("FAIL redir_next_valid got %b want 1", dq.valid); end
    vecs++; if (dq.pc !== 32'h100) begin errs++; $display("FAIL redir_next_pc got %h want 00000100", dq.pc); end
    vecs++; if (count !== 3'd1) begin errs++; $display("FAIL redir_next_count got %0d want 1", count); end
    tick(0, 1, 32'h203, 0, 0, 0);
    vecs++; if (rom_addr !== 32'h200) begin errs++; $display("FAIL redir_align got %h want 00000200", rom_addr); end
  endtask

  task automatic test_stream;
    logic [31:0] want;
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      want = 32'(i) * 32'd4;
      vecs++; if (dq.pc !== want || dq.instr !== sb[0].instr) begin errs++; $display("FAIL stream_%0d pc %h instr %h want pc %h instr %h", i, dq.pc, dq.instr, want, sb[0].instr); end
      tick(0, 0, 0, 0, 0, 1);
      vecs++; if (count !== 3'd1) begin errs++; $display("FAIL stream_count_%0d got %0d want 1", i, count); end
    end
    tick(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    vecs++; if (rom_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_pre got %h want fffffffc", rom_addr); end
    tick(0, 0, 0, 0, 0, 0);
    vecs++; if (rom_addr !== 32'h0) begin errs++; $display("FAIL wrap_addr got %h want 00000000", rom_addr); end
    vecs++; if (dq.pc !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_head got %h want fffffffc", dq.pc); end
  endtask

  task automatic test_priority;
    tick(0, 1, 32'h300, 1, 32'h500, 0);
    vecs++; if (rom_addr !== 32'h300) begin errs++; $display("FAIL prio_redir got %h want 00000300", rom_addr); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL prio_count got %0d want 0", count); end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 1);
    tick(1, 1, 32'h700, 1, 32'h900, 1);
    vecs++; if (rom_addr !== 32'h0) begin errs++; $display("FAIL prio_rst_addr got %h want 00000000", rom_addr); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL prio_rst_count got %0d want 0", count); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL prio_rst_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back;
    logic        r;
    logic        rv;
    logic        pt;
    logic        rdy;
    logic [31:0] ppc;
    logic [31:0] rpc;
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      vecs++; if (rom_addr !== m_pc) begin errs++; $display("FAIL b2b_addr_%0d got %h want %h", i, rom_addr, m_pc); end
      vecs++; if (count !== 3'(sb.size()) || full !== (sb.size() == DEPTH)) begin errs++; $display("FAIL b2b_count_%0d got %0d full %b want %0d", i, count, full, sb.size()); end
      if (sb.size() != 0) begin
        vecs++; if (dq.valid !== 1'b1 || dq.pc !== sb[0].pc || dq.instr !== sb[0].instr || dq.pred_taken !== sb[0].pt) begin errs++; $display("FAIL b2b_head_%0d got %b %h %h %b want 1 %h %h %b", i, dq.valid, dq.pc, dq.instr, dq.pred_taken, sb[0].pc, sb[0].instr, sb[0].pt); end
      end else begin
        vecs++; if (dq.valid !== 1'b0 || dq.instr !== 32'h13 || dq.pc !== 32'h0) begin errs++; $display("FAIL b2b_empty_%0d got %b %h %h want 0 00000013 00000000", i, dq.valid, dq.instr, dq.pc); end
      end
      rdy = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      pt  = ($urandom_range(0, 7) == 0);
      ppc = $urandom;
      rv  = ($urandom_range(0, 31) == 0);
      rpc = $urandom;
      r   = ($urandom_range(0, 127) == 0);
      tick(r, rv, rpc, pt, ppc, rdy);
    end
  endtask

  initial begin
    rst            = 1'b1;
    pred_taken     = 1'b0;
    pred_pc        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dq.ready       = 1'b0;
    m_pc           = '0;
    test_reset();
    test_fill();
    test_predict();
    test_redirect();
    test_stream();
    test_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
